tlul_mem_bist_host: RTL and testbench

TL-UL host that writes a deterministic pattern over a word range of a TL-UL memory device, reads it back, and compares. It is the initiator end of the single-outstanding TL-UL device path used by the on-chip SRAM wrapper. It sits on a host port of the crossbar for bring-up and scrub testing of that memory. It issues one transaction at a time, reports per-word errors, and raises a completion pulse.

---
 rtl/tlul_mem_bist_host_if.sv | 68 ++++++
 rtl/tlul_mem_bist_host.sv | 156 +++++++++++++++
 tb/tb_tlul_mem_bist_host.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_mem_bist_host_if.sv
// TL-UL types and the host/device bus bundle
// used by the memory BIST host.
package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = 4;
  localparam int TL_SZW = 2;

  localparam logic [3:0] MuBi4False = 4'h9;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    tl_a_user_t        a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    tl_d_user_t        d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

interface tlul_mem_bist_host_if;
  import tlul_pkg::*;
  tl_h2d_t h2d;
  tl_d2h_t d2h;
  modport master (output h2d, input d2h);
  modport slave  (input h2d, output d2h);
endinterface

// File: rtl/tlul_mem_bist_host.sv
// TL-UL memory BIST host: writes a seeded pattern
// over a word range, reads it back and compares.
module tlul_mem_bist_host
  import tlul_pkg::*;
#(
  parameter int unsigned       CntW     = 12,
  parameter logic [TL_AIW-1:0] SourceId = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [31:0]     base_addr_i,
  input  logic [CntW-1:0] num_words_i,
  input  logic [31:0]     pattern_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [CntW-1:0] err_count_o,
  output logic [31:0]     first_err_addr_o,
  output tl_h2d_t         tl_o,
  input  tl_d2h_t         tl_i
);
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RSP,
    ST_RD_REQ,
    ST_RD_RSP,
    ST_DONE
  } state_e;

  state_e          r_state, w_state_d;
  logic [31:0]     r_base, r_pat, r_first;
  logic [CntW-1:0] r_num, r_idx, r_cnt;
  logic            r_err;
  logic            w_req, w_rsp, w_wr;
  logic            w_last, w_take, w_err_ev;
  logic            w_start;
  logic [31:0]     w_addr, w_exp;
  logic            w_unused;

  assign w_req = (r_state == ST_WR_REQ) ||
                 (r_state == ST_RD_REQ);
  assign w_rsp = (r_state == ST_WR_RSP) ||
                 (r_state == ST_RD_RSP);
  assign w_wr  = (r_state == ST_WR_REQ);

  assign w_start = (r_state == ST_IDLE) && start_i;
  assign w_last  = (r_idx == r_num - CntW'(1));
  assign w_take  = w_rsp && tl_i.d_valid;
  assign w_addr  = r_base + (32'(r_idx) << 2);
  assign w_exp   = r_pat ^ 32'(r_idx);

  assign w_err_ev = w_take &&
    (tl_i.d_error ||
     ((r_state == ST_RD_RSP) &&
      (tl_i.d_data != w_exp)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_d = (num_words_i == '0) ?
                      ST_DONE : ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (tl_i.a_ready) w_state_d = ST_WR_RSP;
      end
      ST_WR_RSP: begin
        if (tl_i.d_valid) begin
          w_state_d = w_last ? ST_RD_REQ : ST_WR_REQ;
        end
      end
      ST_RD_REQ: begin
        if (tl_i.a_ready) w_state_d = ST_RD_RSP;
      end
      ST_RD_RSP: begin
        if (tl_i.d_valid) begin
          w_state_d = w_last ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_DONE: w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  // A fields come only from state and idx, so they
  // cannot move while a request is stalled.
  always_comb begin
    tl_o = '0;
    if (w_req) begin
      tl_o.a_valid   = 1'b1;
      tl_o.a_opcode  = w_wr ? PutFullData : Get;
      tl_o.a_size    = 2'd2;
      tl_o.a_mask    = 4'hF;
      tl_o.a_source  = SourceId;
      tl_o.a_address = w_addr;
      tl_o.a_data    = w_wr ? w_exp : '0;
      tl_o.a_user.instr_type = MuBi4False;
    end
    tl_o.d_ready = w_rsp;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_base  <= '0;
      r_pat   <= '0;
      r_num   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_first <= '0;
    end else begin
      if (w_start) begin
        r_base  <= {base_addr_i[31:2], 2'b00};
        r_pat   <= pattern_i;
        r_num   <= num_words_i;
        r_idx   <= '0;
        r_err   <= 1'b0;
        r_cnt   <= '0;
        r_first <= '0;
      end
      if (w_take) begin
        r_idx <= w_last ? '0 : r_idx + CntW'(1);
      end
      if (w_err_ev) begin
        r_err <= 1'b1;
        if (r_cnt != {CntW{1'b1}}) begin
          r_cnt <= r_cnt + CntW'(1);
        end
        if (!r_err) r_first <= w_addr;
      end
    end
  end

  assign busy_o           = (r_state != ST_IDLE);
  assign done_o           = (r_state == ST_DONE);
  assign err_o            = r_err;
  assign err_count_o      = r_cnt;
  assign first_err_addr_o = r_first;

  assign w_unused = ^{tl_i.d_opcode, tl_i.d_param,
                      tl_i.d_size, tl_i.d_source,
                      tl_i.d_sink, tl_i.d_user,
                      base_addr_i[1:0]};
endmodule

// File: tb/tb_tlul_mem_bist_host.sv
// Bench for tlul_mem_bist_host: random TL-UL memory
// responder and a word-level model of the BIST run.
module tb_tlul_mem_bist_host;
  import tlul_pkg::*;

  localparam int CntW = 12;
  localparam int Sat  = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i;
  logic [31:0]     base_addr_i;
  logic [CntW-1:0] num_words_i;
  logic [31:0]     pattern_i;
  logic            busy_o, done_o, err_o;
  logic [CntW-1:0] err_count_o;
  logic [31:0]     first_err_addr_o;

  int n_chk  = 0;
  int n_fail = 0;

  tlul_mem_bist_host_if bus ();

  always #5 clk = ~clk;

  tlul_mem_bist_host #(.CntW(CntW)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_i          (start_i),
    .base_addr_i      (base_addr_i),
    .num_words_i      (num_words_i),
    .pattern_i        (pattern_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .err_count_o      (err_count_o),
    .first_err_addr_o (first_err_addr_o),
    .tl_o             (bus.h2d),
    .tl_i             (bus.d2h)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // Responder knobs and transaction log
  int          ar_pct = 100;
  int          dmax   = 0;
  bit          flip_en = 1'b0;
  bit          werr    = 1'b0;
  logic [31:0] flip_addr = '0;
  bit          saw_av  = 1'b0;
  tl_h2d_t     log_q[$];
  logic [31:0] mem [logic [31:0]];

  initial begin : resp
    bit          a_fire, d_fire, pend, stall;
    int          pend_dly, outst;
    tl_h2d_t     a_req, stall_a;
    tl_d2h_t     r, pend_rsp;
    logic [31:0] rd;
    pend = 0; stall = 0; outst = 0; pend_dly = 0;
    pend_rsp = '0;
    stall_a = '0;
    bus.d2h = '0;
    bus.d2h.a_ready = 1'b1;
    forever begin
      @(negedge clk);
      a_fire = bus.h2d.a_valid && bus.d2h.a_ready;
      d_fire = bus.d2h.d_valid && bus.h2d.d_ready;
      if (bus.h2d.a_valid) saw_av = 1'b1;
      if (stall && rst_n) begin
        chk("a_stable", 128'(bus.h2d), 128'(stall_a));
      end
      stall = rst_n && bus.h2d.a_valid &&
              !bus.d2h.a_ready;
      stall_a = bus.h2d;
      a_req = bus.h2d;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend = 0;
        outst = 0;
        stall = 0;
        bus.d2h = '0;
        bus.d2h.a_ready = 1'b1;
      end else begin
        if (d_fire) begin
          bus.d2h.d_valid = 1'b0;
          outst--;
        end
        if (a_fire) begin
          chk("one_outstanding", 128'(outst), 128'(0));
          outst++;
          log_q.push_back(a_req);
          pend_rsp = '0;
          pend_rsp.d_valid  = 1'b1;
          pend_rsp.d_size   = 2'd2;
          pend_rsp.d_source = a_req.a_source;
          if (a_req.a_opcode == PutFullData) begin
            mem[a_req.a_address] = a_req.a_data;
            pend_rsp.d_opcode = AccessAck;
            pend_rsp.d_error  = werr;
          end else begin
            rd = mem.exists(a_req.a_address) ?
                 mem[a_req.a_address] : 32'h0;
            if (flip_en && a_req.a_address == flip_addr)
              rd = rd ^ 32'h1;
            pend_rsp.d_opcode = AccessAckData;
            pend_rsp.d_data   = rd;
          end
          pend = 1;
          pend_dly = $urandom_range(dmax, 0);
        end
        if (pend && !bus.d2h.d_valid) begin
          if (pend_dly == 0) begin
            r = pend_rsp;
            r.a_ready = bus.d2h.a_ready;
            bus.d2h = r;
            pend = 0;
          end else begin
            pend_dly--;
          end
        end
        bus.d2h.a_ready =
          ($urandom_range(99, 0) < ar_pct);
      end
    end
  end

  task automatic do_run(input logic [31:0] base,
                        input int n,
                        input logic [31:0] pat,
                        input bit hold,
                        input bit timed);
    logic [31:0] b, a, efirst;
    int          c, ecnt;
    bit          eany;
    tl_h2d_t     x;
    b = base & 32'hFFFF_FFFC;
    ecnt = 0;
    efirst = '0;
    eany = 0;
    for (int i = 0; i < 2 * n; i++) begin
      a = b + 32'(4 * (i % n));
      if ((i < n && werr) ||
          (i >= n && flip_en && a == flip_addr)) begin
        if (!eany) efirst = a;
        eany = 1;
        if (ecnt < Sat) ecnt++;
      end
    end
    log_q.delete();
    saw_av = 1'b0;
    @(posedge clk);
    #1;
    start_i = 1'b1;
    base_addr_i = base;
    num_words_i = CntW'(n);
    pattern_i = pat;
    @(negedge clk);
    chk("busy_c0", 128'(busy_o), 128'(0));
    @(posedge clk);
    #1;
    if (!hold) start_i = 1'b0;
    c = 1;
    @(negedge clk);
    chk("busy_c1", 128'(busy_o), 128'(1));
    chk("avalid_c1", 128'(bus.h2d.a_valid),
        128'(n != 0));
    chk("errclr_c1",
        128'({err_o, err_count_o, first_err_addr_o}),
        128'(0));
    while (!done_o && c < 40000) begin
      @(negedge clk);
      c++;
    end
    start_i = 1'b0;
    if (!done_o) begin
      chk("done_timeout", 128'(0), 128'(1));
    end else if (timed) begin
      chk("done_cycle", 128'(c), 128'(4 * n + 1));
    end
    @(negedge clk);
    chk("done_pulse", 128'(done_o), 128'(0));
    chk("busy_idle", 128'(busy_o), 128'(0));
    chk("saw_avalid", 128'(saw_av), 128'(n != 0));
    chk("txn_count", 128'(log_q.size()), 128'(2 * n));
    for (int i = 0; i < 2 * n && i < log_q.size(); i++) begin
      x = '0;
      x.a_valid   = 1'b1;
      x.a_opcode  = (i < n) ? PutFullData : Get;
      x.a_size    = 2'd2;
      x.a_mask    = 4'hF;
      x.a_address = b + 32'(4 * (i % n));
      x.a_data    = (i < n) ? (pat ^ 32'(i)) : 32'h0;
      x.a_user.instr_type = MuBi4False;
      chk("a_txn", 128'(log_q[i]), 128'(x));
    end
    chk("err_o", 128'(err_o), 128'(eany));
    chk("err_count", 128'(err_count_o), 128'(ecnt));
    chk("first_err", 128'(first_err_addr_o),
        128'(efirst));
  endtask

  task automatic set_rsp(input int ar, input int dm,
                         input bit fe,
                         input logic [31:0] fa,
                         input bit we);
    ar_pct = ar;
    dmax = dm;
    flip_en = fe;
    flip_addr = fa;
    werr = we;
  endtask

  initial begin : main
    int          c, n;
    bit          hit;
    logic [31:0] b;
    rst_n = 1'b1;
    start_i = 1'b0;
    base_addr_i = '0;
    num_words_i = '0;
    pattern_i = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tl", 128'(bus.h2d), 128'(0));
    chk("rst_status",
        128'({busy_o, done_o, err_o, err_count_o,
              first_err_addr_o}), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    set_rsp(100, 0, 0, 32'h0, 0);
    do_run(32'h1000, 4, 32'hA5A5_0000, 0, 1);
    set_rsp(100, 0, 1, 32'h1008, 0);
    do_run(32'h1000, 4, 32'hA5A5_0000, 0, 1);
    set_rsp(100, 0, 0, 32'h0, 0);
    do_run(32'h1000, 4, 32'hA5A5_0000, 0, 1);
    do_run(32'h1000, 0, 32'h1234_5678, 0, 1);
    do_run(32'h3000, 5, 32'h0F0F_F0F0, 1, 1);
    set_rsp(100, 0, 0, 32'h0, 1);
    do_run(32'h4000, 3, 32'hDEAD_BEEF, 0, 1);
    set_rsp(30, 4, 0, 32'h0, 0);
    do_run(32'h1000, 4, 32'hA5A5_0000, 0, 0);
    set_rsp(100, 0, 0, 32'h0, 0);
    do_run(32'hFFFF_FFF8, 4, 32'h5555_AAAA, 0, 1);

    set_rsp(100, 0, 0, 32'h0, 1);
    @(posedge clk);
    #1;
    start_i = 1'b1;
    base_addr_i = 32'h2000;
    num_words_i = CntW'(8);
    pattern_i = 32'hC0DE_0000;
    @(posedge clk);
    #1 start_i = 1'b0;
    hit = 0;
    for (c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      hit = bus.h2d.a_valid &&
            bus.h2d.a_opcode == PutFullData &&
            bus.h2d.a_address == 32'h2008;
    end
    chk("rst_reach", 128'(hit), 128'(1));
    chk("pre_rst_err", 128'(err_o), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_avalid_async", 128'(bus.h2d.a_valid),
        128'(0));
    chk("rst_tl_mid", 128'(bus.h2d), 128'(0));
    chk("rst_status_mid",
        128'({busy_o, done_o, err_o, err_count_o,
              first_err_addr_o}), 128'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_rsp(100, 0, 0, 32'h0, 0);
    do_run(32'h2000, 4, 32'hC0DE_0000, 0, 1);

    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(10, 1);
      b = $urandom;
      set_rsp($urandom_range(100, 20),
              $urandom_range(4, 0),
              bit'($urandom_range(1, 0)),
              (b & 32'hFFFF_FFFC) +
                32'(4 * $urandom_range(n - 1, 0)),
              bit'($urandom_range(3, 0) == 0));
      do_run(b, n, $urandom, 0, 0);
    end

    set_rsp(100, 0, 1, 32'h8000 + 32'd40, 1);
    do_run(32'h8000, Sat, 32'h9E37_79B9, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end
endmodule
